// File: rtl/ram_be_hs.sv
// Single-port data RAM with byte strobes, valid/ready request/response handshakes
// and address error reporting; a post-reset sweep zeroes the array when INIT_ZERO=1.
module ram_be_hs #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 4096,
   parameter int ADDR_W    = 32,
   parameter bit INIT_ZERO = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [ADDR_W-1:0]     req_addr_i,
   input  logic [DATA_W-1:0]     req_wdata_i,
   input  logic [DATA_W/8-1:0]   req_be_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_W-1:0]     rsp_rdata_o,
   output logic                  rsp_err_o
);

   localparam int BE_W  = DATA_W / 8;
   localparam int OFF   = $clog2(BE_W);
   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BE_W - 1);

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  cnt_q, cnt_d;
   logic              run_en_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] word_addr;
   logic [IDX_W-1:0]  idx;
   logic              addr_err;
   logic              accept;

   // Misaligned or beyond the array; upper index bits must be zero.
   assign word_addr = req_addr_i >> OFF;
   assign idx       = word_addr[IDX_W-1:0];
   assign addr_err  = (|(req_addr_i & OFF_MASK)) || (word_addr >= ADDR_W'(DEPTH));

   // run_en_q keeps ready low while rst_n is asserted even when no sweep runs.
   assign req_ready_o = run_en_q && (state_q == ST_RUN) && (!rsp_valid_o || rsp_ready_i);
   assign accept      = req_valid_i && req_ready_o;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == IDX_W'(DEPTH - 1))
            state_d = ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= INIT_ZERO ? ST_INIT : ST_RUN;
         cnt_q    <= '0;
         run_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         run_en_q <= 1'b1;
      end
   end

   // NOTE: the array has no reset branch so it maps onto RAM macros; clearing is done by the sweep.
   always_ff @(posedge clk) begin
      if (state_q == ST_INIT) begin
         mem[cnt_q] <= '0;
      end else if (accept && req_we_i && !addr_err) begin
         for (int k = 0; k < BE_W; k++) begin
            if (req_be_i[k])
               mem[idx][8*k +: 8] <= req_wdata_i[8*k +: 8];
         end
      end
   end

   // One-entry response register; a new accept overwrites it in the same edge it is consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
      end else if (accept) begin
         rsp_valid_o <= 1'b1;
         rsp_err_o   <= addr_err;
         rsp_rdata_o <= (!req_we_i && !addr_err) ? mem[idx] : '0;
      end else if (rsp_ready_i) begin
         rsp_valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ram_be_hs.sv
// Directed, table-driven bench for ram_be_hs (DATA_W=32, DEPTH=16): sweep timing,
// byte strobes, address errors, back-pressure, and reset during sweep/transaction.
module tb_ram_be_hs;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid_i = 1'b0;
   logic              req_ready_o;
   logic              req_we_i = 1'b0;
   logic [ADDR_W-1:0] req_addr_i = '0;
   logic [DATA_W-1:0] req_wdata_i = '0;
   logic [3:0]        req_be_i = '0;
   logic              rsp_valid_o;
   logic              rsp_ready_i = 1'b0;
   logic [DATA_W-1:0] rsp_rdata_o;
   logic              rsp_err_o;

   int n_checks = 0;
   int n_errors = 0;

   ram_be_hs #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_ZERO(1'b1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_we_i    (req_we_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .req_be_i    (req_be_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 with the response consumed.
   task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] rd, output logic er);
      int n = 0;
      req_valid_i = 1'b1;
      req_we_i    = we;
      req_addr_i  = addr;
      req_wdata_i = wdata;
      req_be_i    = be;
      rsp_ready_i = 1'b1;
      @(negedge clk);
      while (!req_ready_o && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("xfer_ready_timeout", 64'(req_ready_o), 64'd1);
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      @(negedge clk);
      check("xfer_rsp_valid", 64'(rsp_valid_o), 64'd1);
      rd = rsp_rdata_o;
      er = rsp_err_o;
      @(posedge clk);
      #1;
   endtask

   // Called right after reset release at posedge+1; counts negedges with ready low.
   task automatic sweep_count(output int n);
      n = 0;
      @(negedge clk);
      while (!req_ready_o && n < 200) begin
         n++;
         @(negedge clk);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          n;
      logic [31:0] got [$];
      logic [31:0] exp_q [3];
      logic [31:0] addr_q [3];
      int          k;

      vecs[0]  = '{"wr8_full",     1'b1, 32'h08, 32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
      vecs[1]  = '{"rd8_full",     1'b0, 32'h08, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{"wr8_be0101",   1'b1, 32'h08, 32'h11223344, 4'b0101, 32'h0,        1'b0};
      vecs[3]  = '{"rd8_merge",    1'b0, 32'h08, 32'h0,        4'b0000, 32'hDE22BE44, 1'b0};
      vecs[4]  = '{"rd6_misalign", 1'b0, 32'h06, 32'h0,        4'b0000, 32'h0,        1'b1};
      vecs[5]  = '{"rd40_oor",     1'b0, 32'h40, 32'h0,        4'b0000, 32'h0,        1'b1};
      vecs[6]  = '{"wr40_oor",     1'b1, 32'h40, 32'hFFFFFFFF, 4'b1111, 32'h0,        1'b1};
      vecs[7]  = '{"rd0_unchg",    1'b0, 32'h00, 32'h0,        4'b0000, 32'h0,        1'b0};
      vecs[8]  = '{"wr2_misalign", 1'b1, 32'h02, 32'hCAFEF00D, 4'b1111, 32'h0,        1'b1};
      vecs[9]  = '{"rd0_unchg2",   1'b0, 32'h00, 32'h0,        4'b0000, 32'h0,        1'b0};
      vecs[10] = '{"wr3c_be0",     1'b1, 32'h3C, 32'hAAAA5555, 4'b0000, 32'h0,        1'b0};
      vecs[11] = '{"rd3c_noop",    1'b0, 32'h3C, 32'h0,        4'b0000, 32'h0,        1'b0};
      vecs[12] = '{"wr3c_be1000",  1'b1, 32'h3C, 32'h12345678, 4'b1000, 32'h0,        1'b0};
      vecs[13] = '{"rd3c_byte3",   1'b0, 32'h3C, 32'h0,        4'b0000, 32'h12000000, 1'b0};
      vecs[14] = '{"wr4_full",     1'b1, 32'h04, 32'h01020304, 4'b1111, 32'h0,        1'b0};
      vecs[15] = '{"rd4_full",     1'b0, 32'h04, 32'h0,        4'b0000, 32'h01020304, 1'b0};

      // Test 1: reset values, sweep length, all words zero
      repeat (2) @(posedge clk);
      #1;
      check("rst_req_ready", 64'(req_ready_o), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      check("rst_rsp_rdata", 64'(rsp_rdata_o), 64'd0);
      check("rst_rsp_err",   64'(rsp_err_o),   64'd0);
      rst_n = 1'b1;
      sweep_count(n);
      check("sweep_cycles", 64'(n), 64'd16);
      for (int i = 0; i < DEPTH; i++) begin
         xfer(1'b0, 32'(i * 4), 32'h0, 4'h0, rd, er);
         check($sformatf("init_rd_%0d", i), {32'h0, rd}, 64'h0);
         check($sformatf("init_err_%0d", i), 64'(er), 64'd0);
      end

      // Tests 2-4: table-driven single transactions
      foreach (vecs[i]) begin
         xfer(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er);
         check({vecs[i].name, "_rdata"}, {32'h0, rd}, {32'h0, vecs[i].exp_rdata});
         check({vecs[i].name, "_err"}, 64'(er), 64'(vecs[i].exp_err));
      end

      // Read after write in consecutive accepts
      req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h20;
      req_wdata_i = 32'h55AA55AA; req_be_i = 4'hF; rsp_ready_i = 1'b1;
      @(negedge clk);
      check("raw_wr_ready", 64'(req_ready_o), 64'd1);
      @(posedge clk);
      #1 req_we_i = 1'b0;
      @(negedge clk);
      check("raw_wr_rsp", {31'h0, rsp_valid_o, rsp_rdata_o}, {31'h0, 1'b1, 32'h0});
      check("raw_rd_ready", 64'(req_ready_o), 64'd1);
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      @(negedge clk);
      check("raw_rd_rsp", {31'h0, rsp_valid_o, rsp_rdata_o}, {31'h0, 1'b1, 32'h55AA55AA});
      @(posedge clk);
      #1;

      // Test 5: back-pressure then full-rate drain
      addr_q = '{32'h10, 32'h14, 32'h18};
      exp_q  = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3};
      for (int i = 0; i < 3; i++) xfer(1'b1, addr_q[i], exp_q[i], 4'hF, rd, er);
      k = 0;
      for (int cyc = 0; cyc < 9; cyc++) begin
         rsp_ready_i = (cyc >= 4);
         req_valid_i = (k < 3);
         req_we_i    = 1'b0;
         req_addr_i  = (k < 3) ? addr_q[k] : 32'h0;
         @(negedge clk);
         if (cyc >= 1 && cyc <= 3) begin
            check($sformatf("stall_ready_%0d", cyc), 64'(req_ready_o), 64'd0);
            check($sformatf("stall_rsp_%0d", cyc), {31'h0, rsp_valid_o, rsp_rdata_o},
                  {31'h0, 1'b1, exp_q[0]});
         end
         if (cyc >= 4 && k < 3)
            check($sformatf("drain_ready_%0d", cyc), 64'(req_ready_o), 64'd1);
         if (cyc == 8)
            check("drain_idle_valid", 64'(rsp_valid_o), 64'd0);
         if (rsp_valid_o && rsp_ready_i) got.push_back(rsp_rdata_o);
         if (req_valid_i && req_ready_o) k++;
         @(posedge clk);
         #1;
      end
      check("drain_count", 64'(got.size()), 64'd3);
      for (int i = 0; i < 3; i++)
         check($sformatf("drain_data_%0d", i), (i < got.size()) ? {32'h0, got[i]} : 64'hX,
               {32'h0, exp_q[i]});
      req_valid_i = 1'b0;

      // Test 6a: reset pulse at sweep cycle 7
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (7) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check("mid_sweep_ready", 64'(req_ready_o), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      sweep_count(n);
      check("resweep_cycles", 64'(n), 64'd16);

      // Test 6b: reset while a response is pending
      xfer(1'b1, 32'h08, 32'h77777777, 4'hF, rd, er);
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h08; rsp_ready_i = 1'b0;
      @(posedge clk);
      #1 req_valid_i = 1'b0;
      check("pend_valid", {31'h0, rsp_valid_o, rsp_rdata_o}, {31'h0, 1'b1, 32'h77777777});
      #2 rst_n = 1'b0;
      #1 check("pend_rst_rsp", {31'h0, rsp_valid_o, rsp_rdata_o}, 64'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      sweep_count(n);
      check("resweep2_cycles", 64'(n), 64'd16);
      xfer(1'b0, 32'h08, 32'h0, 4'h0, rd, er);
      check("resweep2_zero", {32'h0, rd}, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
